// File: rtl/vscpu_irq_param.sv
// vscpu_irq_param: multi-cycle VerySimpleCPU core with parametrised widths,
// a configurable reset PC and a single-level vectored interrupt.
// Every instruction runs FETCH -> DECODE -> OPERAND -> EXEC over one
// synchronous-read RAM port. Interrupt entry adds INT0 (read the vector)
// and INT1 (save the return PC and jump).
`timescale 1ns/1ps
module vscpu_irq_param #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int RESET_PC     = 0,
    parameter int INT_VEC_ADDR = 5,
    parameter int INT_PC_ADDR  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_fromRAM,
    input  logic              interrupt,
    output logic              wrEn,
    output logic [ADDR_W-1:0] addr_toRAM,
    output logic [DATA_W-1:0] data_toRAM,
    output logic              int_ack,
    output logic              in_service
);

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] VEC_A      = ADDR_W'(INT_VEC_ADDR);
    localparam logic [ADDR_W-1:0] RET_A      = ADDR_W'(INT_PC_ADDR);
    localparam logic [DATA_W-1:0] DW_VAL     = DATA_W'(DATA_W);

    // Opcode classes (op[3:1]); op[0] selects the immediate form.
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_CP   = 3'd4;
    localparam logic [2:0] OP_CPI  = 3'd5;
    localparam logic [2:0] OP_BZJ  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_OPERAND = 3'd2,
        S_EXEC    = 3'd3,
        S_INT0    = 3'd4,
        S_INT1    = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg;
    logic [DATA_W-1:0]   iw_reg;
    logic [DATA_W-1:0]   r1_reg;
    logic                pending_reg;
    logic                in_service_reg;

    // Fields of the latched instruction word.
    logic [2:0]          opc;
    logic                imm;
    logic [ADDR_W-1:0]   a_fld;
    logic [ADDR_W-1:0]   b_fld;
    logic [DATA_W-1:0]   b_ext;

    // Fields of the word arriving during DECODE (IW is not latched yet).
    logic [2:0]          dec_opc;
    logic                dec_imm;
    logic [ADDR_W-1:0]   dec_a;
    logic [ADDR_W-1:0]   dec_b;

    logic [DATA_W-1:0]   v_val;
    logic [DATA_W-1:0]   alu_res;
    logic [ADDR_W-1:0]   pc_exec;
    logic                irq_req;
    logic                is_return;

    assign opc     = iw_reg[DATA_W-1:DATA_W-3];
    assign imm     = iw_reg[DATA_W-4];
    assign a_fld   = iw_reg[2*ADDR_W-1:ADDR_W];
    assign b_fld   = iw_reg[ADDR_W-1:0];
    assign b_ext   = {{(DATA_W-ADDR_W){1'b0}}, b_fld};

    assign dec_opc = data_fromRAM[DATA_W-1:DATA_W-3];
    assign dec_imm = data_fromRAM[DATA_W-4];
    assign dec_a   = data_fromRAM[2*ADDR_W-1:ADDR_W];
    assign dec_b   = data_fromRAM[ADDR_W-1:0];

    assign in_service = in_service_reg;

    // EXEC datapath: ALU result, next PC, return detection, entry decision.
    always_comb begin
        v_val   = imm ? b_ext : data_fromRAM;
        alu_res = '0;
        case (opc)
            OP_ADD:  alu_res = r1_reg + v_val;
            OP_NAND: alu_res = ~(r1_reg & v_val);
            OP_SRL:  alu_res = (v_val < DW_VAL) ? (r1_reg >> v_val)
                                                : (r1_reg << (v_val - DW_VAL));
            OP_LT:   alu_res = {{(DATA_W-1){1'b0}}, (r1_reg < v_val)};
            OP_MUL:  alu_res = r1_reg * v_val;
            default: alu_res = '0;
        endcase

        pc_exec = pc_reg + ADDR_W'(1);
        if (opc == OP_BZJ) begin
            if (imm) begin
                pc_exec = r1_reg[ADDR_W-1:0] + b_fld;
            end else if (data_fromRAM == '0) begin
                pc_exec = r1_reg[ADDR_W-1:0];
            end
        end

        // Returning from the ISR still sees in_service=1 here, so any
        // queued request waits one more instruction before it is taken.
        is_return = (opc == OP_BZJ) && (a_fld == RET_A) && in_service_reg;
        irq_req   = (pending_reg || interrupt) && !in_service_reg;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: fixed 4-cycle instruction, optional 2-cycle entry.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = S_OPERAND;
            S_OPERAND: state_next = S_EXEC;
            S_EXEC:    state_next = irq_req ? S_INT0 : S_FETCH;
            S_INT0:    state_next = S_INT1;
            S_INT1:    state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // RAM port and handshake outputs; all forced idle while rst is high
    // so a reset landing on EXEC or INT1 never writes.
    always_comb begin
        wrEn       = 1'b0;
        addr_toRAM = '0;
        data_toRAM = '0;
        int_ack    = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: addr_toRAM = pc_reg;
                S_DECODE: begin
                    // Register CP/CPI fetch mem[B] first; everything else mem[A].
                    if (!dec_imm && (dec_opc == OP_CP || dec_opc == OP_CPI)) begin
                        addr_toRAM = dec_b;
                    end else begin
                        addr_toRAM = dec_a;
                    end
                end
                S_OPERAND: begin
                    // CPI dereferences the pointer that just arrived from mem[B].
                    if (!imm && opc == OP_CPI) begin
                        addr_toRAM = data_fromRAM[ADDR_W-1:0];
                    end else begin
                        addr_toRAM = b_fld;
                    end
                end
                S_EXEC: begin
                    case (opc)
                        OP_BZJ: ;
                        OP_CP: begin
                            wrEn       = 1'b1;
                            addr_toRAM = a_fld;
                            data_toRAM = imm ? b_ext : data_fromRAM;
                        end
                        OP_CPI: begin
                            wrEn       = 1'b1;
                            addr_toRAM = imm ? r1_reg[ADDR_W-1:0] : a_fld;
                            data_toRAM = data_fromRAM;
                        end
                        default: begin
                            wrEn       = 1'b1;
                            addr_toRAM = a_fld;
                            data_toRAM = alu_res;
                        end
                    endcase
                end
                S_INT0: addr_toRAM = VEC_A;
                S_INT1: begin
                    wrEn       = 1'b1;
                    addr_toRAM = RET_A;
                    data_toRAM = {{(DATA_W-ADDR_W){1'b0}}, pc_reg};
                    int_ack    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Architectural registers: PC, IW, R1, pending latch, in-service flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC_A;
            iw_reg         <= '0;
            r1_reg         <= '0;
            pending_reg    <= 1'b0;
            in_service_reg <= 1'b0;
        end else begin
            // Entry clears the latch, but a request seen in that same cycle
            // is kept so it is not lost.
            if (state_reg == S_INT1) begin
                pending_reg <= 1'b0;
            end
            if (interrupt) begin
                pending_reg <= 1'b1;
            end
            case (state_reg)
                S_DECODE:  iw_reg <= data_fromRAM;
                S_OPERAND: r1_reg <= data_fromRAM;
                S_EXEC: begin
                    pc_reg <= pc_exec;
                    if (is_return) begin
                        in_service_reg <= 1'b0;
                    end
                end
                S_INT1: begin
                    pc_reg         <= data_fromRAM[ADDR_W-1:0];
                    in_service_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
